// File: rtl/px_pace_fifo_pkg.sv
// Shared constants for the pixel pacing FIFO.
package px_pace_fifo_pkg;

    localparam int MAX_PIXEL_BITS    = 24;
    localparam int PX_FIFO_DEPTH_DEF = 4;
    localparam int PX_GAP_BITS       = 4;

endpackage

// File: rtl/px_pace_fifo.sv
// Pixel FIFO that releases stored pixels as single-cycle strobes separated by a
// programmable minimum number of idle cycles.
module px_pace_fifo
    import px_pace_fifo_pkg::*;
#(
    parameter int PX_FIFO_DEPTH = PX_FIFO_DEPTH_DEF,
    parameter int PX_W          = MAX_PIXEL_BITS
) (
    input  logic                           clk_i,
    input  logic                           nreset_i,
    input  logic                           px_rdy_i,
    input  logic [PX_W-1:0]                in_pixel_i,
    input  logic [PX_GAP_BITS-1:0]         gap_i,
    input  logic                           flush_i,
    output logic                           px_rdy_o,
    output logic [PX_W-1:0]                out_pixel_o,
    output logic [$clog2(PX_FIFO_DEPTH):0] level_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           overflow_o
);

    localparam int               PTR_W    = $clog2(PX_FIFO_DEPTH);
    localparam int               LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(PX_FIFO_DEPTH);

    logic [PX_W-1:0]        mem_q [PX_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   ovf_q, ovf_d;
    logic [PX_GAP_BITS-1:0] pace_q, pace_d;
    logic                   px_rdy_q, px_rdy_d;
    logic [PX_W-1:0]        out_q, out_d;
    logic                   wr_en_s;
    logic                   pop_s;

    // Write/pop qualification; full is taken from the registered flag so a
    // same-cycle pop never makes room for a write.
    always_comb begin
        wr_en_s = px_rdy_i & ~full_q & ~flush_i;
        pop_s   = ~empty_q & (pace_q == {PX_GAP_BITS{1'b0}}) & ~flush_i;
    end

    // Next-state for pointers, occupancy, pacing and output registers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        pace_d   = pace_q;
        px_rdy_d = 1'b0;
        out_d    = out_q;

        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            level_d  = {LVL_W{1'b0}};
            ovf_d    = 1'b0;
            pace_d   = {PX_GAP_BITS{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                px_rdy_d = 1'b1;
                out_d    = mem_q[rd_ptr_q];
                pace_d   = gap_i;
            end else if (pace_q != {PX_GAP_BITS{1'b0}}) begin
                pace_d   = pace_q - PX_GAP_BITS'(1);
            end else begin
                pace_d   = pace_q;
            end

            if (wr_en_s && !pop_s) begin
                level_d = level_q + LVL_W'(1);
            end else if (!wr_en_s && pop_s) begin
                level_d = level_q - LVL_W'(1);
            end else begin
                level_d = level_q;
            end

            if (px_rdy_i && full_q) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end

        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == {LVL_W{1'b0}});
    end

    // Control and output state registers.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            pace_q   <= {PX_GAP_BITS{1'b0}};
            px_rdy_q <= 1'b0;
            out_q    <= {PX_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            pace_q   <= pace_d;
            px_rdy_q <= px_rdy_d;
            out_q    <= out_d;
        end
    end

    // Pixel storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= in_pixel_i;
        end
    end

    assign px_rdy_o    = px_rdy_q;
    assign out_pixel_o = out_q;
    assign level_o     = level_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_px_pace_fifo.sv
// Bench for px_pace_fifo: directed scenarios plus random traffic, checked by a
// queue-based reference model feeding an output scoreboard.
module tb_px_pace_fifo;
    import px_pace_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int PW    = MAX_PIXEL_BITS;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   px_rdy_i = 1'b0;
    logic [PW-1:0]          in_pixel_i = '0;
    logic [PX_GAP_BITS-1:0] gap_i = '0;
    logic                   flush_i = 1'b0;
    logic                   px_rdy_o;
    logic [PW-1:0]          out_pixel_o;
    logic [LW-1:0]          level_o;
    logic                   full_o, empty_o, overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [PW-1:0] mq[$];
    int            pace_m = 0;
    bit            ovf_m = 1'b0;
    bit            was_full_m;
    logic [PW-1:0] last_m = '0;
    logic [PW-1:0] exp_d[$];
    int            exp_c[$];
    int            edge_cnt = 0;
    int            max_level = 0;

    px_pace_fifo #(.PX_FIFO_DEPTH(DEPTH), .PX_W(PW)) dut (
        .clk_i(clk), .nreset_i(rst_n), .px_rdy_i(px_rdy_i), .in_pixel_i(in_pixel_i),
        .gap_i(gap_i), .flush_i(flush_i), .px_rdy_o(px_rdy_o), .out_pixel_o(out_pixel_o),
        .level_o(level_o), .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus a countdown, updated at each clock edge.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete(); exp_d.delete(); exp_c.delete();
            pace_m = 0; ovf_m = 1'b0; last_m = '0;
        end else begin
            edge_cnt++;
            if (flush_i) begin
                mq.delete(); pace_m = 0; ovf_m = 1'b0;
            end else begin
                was_full_m = (mq.size() == DEPTH);
                if (mq.size() != 0 && pace_m == 0) begin
                    last_m = mq.pop_front();
                    exp_d.push_back(last_m);
                    exp_c.push_back(edge_cnt);
                    pace_m = int'(gap_i);
                end else if (pace_m > 0) begin
                    pace_m--;
                end
                if (px_rdy_i) begin
                    if (was_full_m) ovf_m = 1'b1;
                    else mq.push_back(in_pixel_i);
                end
            end
        end
    end

    // Monitor: match every output strobe against the scoreboard, check status.
    initial forever begin
        logic [PW-1:0] d;
        int            c;
        @(negedge clk);
        while (exp_c.size() != 0 && exp_c[0] < edge_cnt) begin
            chk("missing_strobe", 1'b0, 64'(exp_d[0]), 64'(exp_c[0]));
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
        end
        if (px_rdy_o === 1'b1) begin
            if (exp_d.size() == 0) begin
                chk("spurious_strobe", 1'b0, 64'(out_pixel_o), 64'(0));
            end else begin
                d = exp_d.pop_front();
                c = exp_c.pop_front();
                chk("out_data", out_pixel_o === d, 64'(out_pixel_o), 64'(d));
                chk("out_timing", c == edge_cnt, 64'(edge_cnt), 64'(c));
            end
        end
        if (int'(level_o) > max_level) max_level = int'(level_o);
        chk("level", int'(level_o) == mq.size() && !$isunknown(level_o), 64'(level_o), 64'(mq.size()));
        chk("full", full_o === (mq.size() == DEPTH), 64'(full_o), 64'(mq.size() == DEPTH));
        chk("empty", empty_o === (mq.size() == 0), 64'(empty_o), 64'(mq.size() == 0));
        chk("overflow", overflow_o === ovf_m, 64'(overflow_o), 64'(ovf_m));
        chk("out_hold", out_pixel_o === last_m, 64'(out_pixel_o), 64'(last_m));
    end

    task automatic step(input logic w, input logic [PW-1:0] d, input logic f);
        @(negedge clk);
        px_rdy_i   = w;
        in_pixel_i = d;
        flush_i    = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || exp_d.size() != 0) && n < 400) begin
            idle(1);
            n++;
        end
        chk("drain_timeout", n < 400, 64'(n), 64'(400));
    endtask

    task automatic chk_reset_vals();
        chk("rst_px_rdy", px_rdy_o === 1'b0, 64'(px_rdy_o), 64'(0));
        chk("rst_out", out_pixel_o === '0, 64'(out_pixel_o), 64'(0));
        chk("rst_level", level_o === '0, 64'(level_o), 64'(0));
        chk("rst_empty", empty_o === 1'b1, 64'(empty_o), 64'(1));
        chk("rst_full", full_o === 1'b0, 64'(full_o), 64'(0));
        chk("rst_ovf", overflow_o === 1'b0, 64'(overflow_o), 64'(0));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single pixel, no gap
        gap_i = 4'd0;
        step(1'b1, 24'h0000A5, 1'b0);
        idle(4);
        chk("single_out", out_pixel_o === 24'h0000A5, 64'(out_pixel_o), 64'h0000A5);
        chk("single_level", level_o === '0, 64'(level_o), 64'(0));

        // paced burst
        gap_i = 4'd3;
        for (int i = 1; i <= 4; i++) step(1'b1, PW'(i), 1'b0);
        drain();

        // overflow with a long gap
        gap_i = 4'd15;
        for (int i = 10; i <= 15; i++) step(1'b1, PW'(i), 1'b0);
        idle(2);
        chk("ovf_set", overflow_o === 1'b1, 64'(overflow_o), 64'(1));
        drain();
        step(1'b0, '0, 1'b1);
        idle(1);

        // pointer wrap with sparse writes
        gap_i = 4'd0;
        max_level = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, PW'(32'h100 + i), 1'b0);
            idle(1);
        end
        drain();
        chk("wrap_max_level", max_level <= 1, 64'(max_level), 64'(1));
        chk("wrap_ovf", overflow_o === 1'b0, 64'(overflow_o), 64'(0));

        // flush with a same-cycle write
        gap_i = 4'd15;
        for (int i = 0; i < 3; i++) step(1'b1, PW'(32'h20 + i), 1'b0);
        step(1'b1, 24'h000077, 1'b1);
        idle(1);
        chk("flush_level", level_o === '0, 64'(level_o), 64'(0));
        chk("flush_empty", empty_o === 1'b1, 64'(empty_o), 64'(1));
        idle(20);

        // mid-stream reset with entries and an active pace count
        for (int i = 0; i < 3; i++) step(1'b1, PW'(32'h30 + i), 1'b0);
        idle(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(25);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) gap_i = PX_GAP_BITS'($urandom_range(0, 4));
            step($urandom_range(0, 99) < 60, PW'($urandom), $urandom_range(0, 99) < 2);
        end
        drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
